// File: rtl/reg_snapshot_streamer.sv
// Register-file and PC snapshot streamer for end-of-run state dumps.
// One-cycle capture on trigger, then (index, data) beats over valid/ready.
module reg_snapshot_streamer #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 15,
    parameter  int PC_SHIFT = 2,
    localparam int IDX_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_trigger,
    input  logic                       i_skip_zero,
    input  logic [NUM_REGS*DATA_W-1:0] i_reg_flat,
    input  logic [DATA_W-1:0]          i_pc,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [IDX_W-1:0]           o_out_idx,
    output logic [DATA_W-1:0]          o_out_data,
    output logic                       o_out_last,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [7:0]                 o_drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(NUM_REGS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [DATA_W-1:0]  r_snap [NUM_REGS+1];
    logic               r_mode;
    logic [7:0]         r_drop_cnt;
    logic               w_capture;
    logic               w_skip;
    logic               w_drop;
    logic [DATA_W-1:0]  w_cur;

    assign w_cur      = r_snap[r_ptr];
    assign w_drop     = i_trigger && (r_state != S_IDLE);
    assign o_drop_cnt = r_drop_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Outputs are pure decodes of the frozen snapshot and pointer, so a
    // presented beat cannot change until the pointer moves on handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_capture   = 1'b0;
        w_skip      = 1'b0;
        o_out_valid = 1'b0;
        o_out_idx   = '0;
        o_out_data  = '0;
        o_out_last  = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_trigger) begin
                    w_capture   = 1'b1;
                    w_ptr_nxt   = '0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                o_busy = 1'b1;
                w_skip = r_mode && (r_ptr != PC_IDX) && (w_cur == '0);
                if (w_skip) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end else begin
                    o_out_valid = 1'b1;
                    o_out_idx   = r_ptr;
                    o_out_data  = w_cur;
                    o_out_last  = (r_ptr == PC_IDX);
                    if (i_out_ready) begin
                        if (r_ptr == PC_IDX) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_ptr_nxt = r_ptr + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i <= NUM_REGS; i++) begin
                r_snap[i] <= '0;
            end
            r_mode <= 1'b0;
        end else if (w_capture) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_snap[i] <= i_reg_flat[i*DATA_W +: DATA_W];
            end
            r_snap[NUM_REGS] <= i_pc >> PC_SHIFT;
            r_mode           <= i_skip_zero;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_reg_snapshot_streamer.sv
// Scoreboard bench: stimulus pushes expected beats, monitors pop and compare.
// Covers both the default build and a 32-bit/31-register/no-shift build.
module tb_reg_snapshot_streamer;

    localparam int DW  = 16;
    localparam int NR  = 15;
    localparam int IW  = 4;
    localparam int DW2 = 32;
    localparam int NR2 = 31;
    localparam int IW2 = 5;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              trig;
    logic              skip;
    logic              ready;
    logic [NR*DW-1:0]  flat;
    logic [DW-1:0]     pc;
    logic              o_valid;
    logic [IW-1:0]     o_idx;
    logic [DW-1:0]     o_data;
    logic              o_last;
    logic              o_busy;
    logic              o_done;
    logic [7:0]        o_drop;

    logic              trig2;
    logic              skip2;
    logic              ready2;
    logic [NR2*DW2-1:0] flat2;
    logic [DW2-1:0]    pc2;
    logic              o_valid2;
    logic [IW2-1:0]    o_idx2;
    logic [DW2-1:0]    o_data2;
    logic              o_last2;
    logic              o_busy2;
    logic              o_done2;
    logic [7:0]        o_drop2;

    reg_snapshot_streamer u_dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_trigger   (trig),
        .i_skip_zero (skip),
        .i_reg_flat  (flat),
        .i_pc        (pc),
        .o_out_valid (o_valid),
        .i_out_ready (ready),
        .o_out_idx   (o_idx),
        .o_out_data  (o_data),
        .o_out_last  (o_last),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_drop_cnt  (o_drop)
    );

    reg_snapshot_streamer #(
        .DATA_W   (DW2),
        .NUM_REGS (NR2),
        .PC_SHIFT (0)
    ) u_dut32 (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_trigger   (trig2),
        .i_skip_zero (skip2),
        .i_reg_flat  (flat2),
        .i_pc        (pc2),
        .o_out_valid (o_valid2),
        .i_out_ready (ready2),
        .o_out_idx   (o_idx2),
        .o_out_data  (o_data2),
        .o_out_last  (o_last2),
        .o_busy      (o_busy2),
        .o_done      (o_done2),
        .o_drop_cnt  (o_drop2)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t q[$];
    beat_t q2[$];

    logic [DW-1:0]  mreg [NR];
    logic [DW-1:0]  mpc;
    logic [DW2-1:0] mreg2 [NR2];
    logic [DW2-1:0] mpc2;

    int n_hs, n_valid, first_cyc, last_cyc, trig_cyc;
    bit done_seen;
    int n_hs2, first_cyc2, last_cyc2;
    bit done_seen2;

    logic          pv, pr, plast_hs, plast;
    logic [IW-1:0] pidx;
    logic [DW-1:0] pdata;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        beat_t e;
        pv = 0; pr = 0; plast_hs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0;
                plast_hs = 0;
            end else begin
                if (plast_hs) chk("done_after_last", 64'(o_done), 64'd1);
                else if (o_done) chk("spurious_done", 64'(o_done), 64'd0);
                if (o_done) done_seen = 1;
                if (pv && !pr) begin
                    chk("hold_valid", 64'(o_valid), 64'd1);
                    chk("hold_idx", 64'(o_idx), 64'(pidx));
                    chk("hold_data", 64'(o_data), 64'(pdata));
                    chk("hold_last", 64'(o_last), 64'(plast));
                end
                if (o_valid) n_valid++;
                plast_hs = 0;
                if (o_valid && ready) begin
                    if (q.size() == 0) begin
                        chk("extra_beat_idx", 64'(o_idx), 64'hFFFF);
                    end else begin
                        e = q.pop_front();
                        chk("beat_idx", 64'(o_idx), 64'(e.idx));
                        chk("beat_data", 64'(o_data), 64'(e.data));
                        chk("beat_last", 64'(o_last), 64'(e.last));
                    end
                    if (n_hs == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    n_hs++;
                    plast_hs = o_last;
                end
                pv = o_valid; pr = ready;
                pidx = o_idx; pdata = o_data; plast = o_last;
            end
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_done2) done_seen2 = 1;
                if (o_valid2 && ready2) begin
                    if (q2.size() == 0) begin
                        chk("w_extra_beat_idx", 64'(o_idx2), 64'hFFFF);
                    end else begin
                        e = q2.pop_front();
                        chk("w_beat_idx", 64'(o_idx2), 64'(e.idx));
                        chk("w_beat_data", 64'(o_data2), 64'(e.data));
                        chk("w_beat_last", 64'(o_last2), 64'(e.last));
                    end
                    if (n_hs2 == 0) first_cyc2 = cyc;
                    last_cyc2 = cyc;
                    n_hs2++;
                end
            end
        end
    end

    task automatic load_flat();
        for (int i = 0; i < NR; i++) flat[i*DW +: DW] = mreg[i];
        pc = mpc;
    endtask

    task automatic rand_regs(input int zero_pct);
        for (int i = 0; i < NR; i++)
            mreg[i] = ($urandom_range(0, 99) < zero_pct) ? '0 : DW'($urandom);
        mpc = ($urandom_range(0, 99) < zero_pct) ? '0 : DW'($urandom);
    endtask

    // Reference: every register in order unless zero-skipping drops it,
    // then the word-scaled PC as the single final beat.
    task automatic expect_stream(input bit mode);
        beat_t e;
        for (int i = 0; i < NR; i++) begin
            if (!(mode && mreg[i] == 0)) begin
                e.idx = 8'(i); e.data = 32'(mreg[i]); e.last = 1'b0;
                q.push_back(e);
            end
        end
        e.idx = 8'(NR); e.data = 32'(mpc / 4); e.last = 1'b1;
        q.push_back(e);
    endtask

    task automatic start(input bit mode);
        load_flat();
        skip = mode;
        n_hs = 0; n_valid = 0; done_seen = 0;
        expect_stream(mode);
        trig_cyc = cyc;
        trig = 1;
        @(posedge clk); #1;
        trig = 0;
    endtask

    task automatic pulse();
        trig = 1;
        @(posedge clk); #1;
        trig = 0;
    endtask

    task automatic run(input int maxc, input bit rnd_ready, input bit mutate);
        int k = 0;
        while (!done_seen && k < maxc) begin
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
            if (mutate) begin
                for (int i = 0; i < NR; i++) flat[i*DW +: DW] = DW'($urandom);
                pc = DW'($urandom);
                skip = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            k++;
        end
        ready = 1;
        chk("stream_done_seen", 64'(done_seen), 64'd1);
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("idle_after_done", 64'(o_busy), 64'd0);
    endtask

    initial begin
        int  k;
        bit  found;
        bit  m;
        beat_t e;
        rst_n = 0; trig = 0; skip = 0; ready = 1; flat = '0; pc = '0;
        trig2 = 0; skip2 = 0; ready2 = 1; flat2 = '0; pc2 = '0;
        n_hs2 = 0; done_seen2 = 0;
        #3;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_idx", 64'(o_idx), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_drop", 64'(o_drop), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Back-to-back full dump with an always-ready sink
        for (int i = 0; i < NR; i++) mreg[i] = DW'(3 * i);
        mpc = 16'h0040;
        start(0);
        run(100, 0, 0);
        chk("t1_beats", 64'(n_hs), 64'd16);
        chk("t1_first_lat", 64'(first_cyc - trig_cyc), 64'd1);
        chk("t1_consecutive", 64'(last_cyc - first_cyc), 64'd15);

        // Zero-skip keeps only nonzero registers plus the PC
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        mreg[2] = 16'd7; mreg[9] = 16'hFFFF; mpc = '0;
        start(1);
        run(100, 0, 0);
        chk("t2_beats", 64'(n_hs), 64'd3);
        chk("t2_valid_cycles", 64'(n_valid), 64'd3);

        for (int i = 0; i < NR; i++) mreg[i] = DW'(3 * i);
        mpc = 16'h0040;
        start(0);
        run(600, 1, 0);
        chk("t3_beats", 64'(n_hs), 64'd16);

        // Triggers while busy are counted and otherwise ignored
        rand_regs(0);
        ready = 0;
        start(0);
        pulse();
        @(posedge clk); #1;
        pulse();
        ready = 1;
        run(100, 0, 0);
        chk("t4_drop2", 64'(o_drop), 64'd2);
        chk("t4_beats", 64'(n_hs), 64'd16);
        rand_regs(30);
        ready = 0;
        start(1);
        trig = 1;
        repeat (300) begin
            @(posedge clk); #1;
        end
        trig = 0;
        chk("t4_drop_sat", 64'(o_drop), 64'd255);
        ready = 1;
        run(100, 0, 0);
        chk("t4_drop_hold", 64'(o_drop), 64'd255);

        // Asynchronous reset in the middle of a stream
        rand_regs(0);
        start(0);
        found = 0;
        k = 0;
        while (!found && k < 50) begin
            @(negedge clk);
            if (o_valid && o_idx == IW'(6)) found = 1;
            k++;
        end
        chk("t5_reach_beat6", 64'(found), 64'd1);
        #2 rst_n = 0;
        #1;
        chk("t5_rst_valid", 64'(o_valid), 64'd0);
        chk("t5_rst_busy", 64'(o_busy), 64'd0);
        chk("t5_rst_drop", 64'(o_drop), 64'd0);
        chk("t5_rst_idx", 64'(o_idx), 64'd0);
        q.delete();
        pv = 0; plast_hs = 0; done_seen = 0;
        @(posedge clk); #1;
        rst_n = 1;
        rand_regs(0);
        start(0);
        run(100, 0, 0);
        chk("t5_restart_beats", 64'(n_hs), 64'd16);

        // Inputs scrambled every cycle after capture; random modes and sinks
        for (int r = 0; r < 6; r++) begin
            rand_regs(40);
            m = 1'($urandom_range(0, 1));
            start(m);
            run(600, 1, 1);
        end
        chk("t6_drop_clean", 64'(o_drop), 64'd0);

        // Wide build: 32-bit data, 31 registers, unscaled PC
        for (int i = 0; i < NR2; i++) begin
            mreg2[i] = DW2'($urandom);
            flat2[i*DW2 +: DW2] = mreg2[i];
            e.idx = 8'(i); e.data = mreg2[i]; e.last = 1'b0;
            q2.push_back(e);
        end
        mpc2 = DW2'($urandom);
        pc2 = mpc2;
        e.idx = 8'(NR2); e.data = mpc2; e.last = 1'b1;
        q2.push_back(e);
        n_hs2 = 0; done_seen2 = 0;
        trig_cyc = cyc;
        trig2 = 1;
        @(posedge clk); #1;
        trig2 = 0;
        flat2 = '0;
        k = 0;
        while (!done_seen2 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("w_done_seen", 64'(done_seen2), 64'd1);
        chk("w_beats", 64'(n_hs2), 64'd32);
        chk("w_first_lat", 64'(first_cyc2 - trig_cyc), 64'd1);
        chk("w_consecutive", 64'(last_cyc2 - first_cyc2), 64'd31);
        chk("w_queue_drained", 64'(q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
